// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: stores decode-lane (PC, INSTR) entries with a per-entry sequence check
// and drains them oldest-first over a valid/ready port. Define TRACE_TSTAMP_EN for per-entry cycle stamps.
module trace_capture_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LANES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           in_valid_i,
    input  logic [LANES*XLEN-1:0]      in_pc_i,
    input  logic [LANES*XLEN-1:0]      in_instr_i,
    input  logic [LANES-1:0]           in_redirect_i,
    input  logic [1:0]                 cfg_mode_i,
    input  logic [XLEN-1:0]            cfg_trig_pc_i,
    input  logic [$clog2(DEPTH)-1:0]   cfg_post_cnt_i,
    input  logic                       arm_i,
    input  logic                       stop_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [XLEN-1:0]            rd_pc_o,
    output logic [XLEN-1:0]            rd_instr_o,
    output logic                       rd_seq_err_o,
    output logic [31:0]                rd_tstamp_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [1:0]                 state_o,
    output logic                       overflow_o,
    output logic [15:0]                seq_err_cnt_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] MODE_STOP = 2'd0;
    localparam logic [1:0] MODE_WRAP = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_n;
    logic [1:0]      mode_q, mode_n;
    logic [XLEN-1:0] trig_pc_q, trig_pc_n;
    logic [AW-1:0]   post_q, post_n;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_n;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_n;
    logic [CW-1:0]   count_q, count_n;
    logic            overflow_q, overflow_n;
    logic [15:0]     err_cnt_q, err_cnt_n;
    logic            hist_v_q, hist_v_n;
    logic [XLEN-1:0] prev_pc_q, prev_pc_n;
    logic            prev_redir_q, prev_redir_n;
    logic            rd_valid_q, rd_valid_n;
    logic            rd_load;
    logic [XLEN-1:0] rd_pc_q, rd_instr_q;
    logic            rd_err_q;

    logic            we    [LANES];
    logic [AW-1:0]   waddr [LANES];
    logic            werr  [LANES];
    logic [XLEN-1:0] lane_pc;
    logic            lane_err;
    logic            lane_store;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic            err_mem   [DEPTH];

    // Next-state: arm/clear, per-lane capture in lane order, or drain bookkeeping
    always_comb begin
        state_n      = state_q;
        mode_n       = mode_q;
        trig_pc_n    = trig_pc_q;
        post_n       = post_q;
        wr_ptr_n     = wr_ptr_q;
        rd_ptr_n     = rd_ptr_q;
        count_n      = count_q;
        overflow_n   = overflow_q;
        err_cnt_n    = err_cnt_q;
        hist_v_n     = hist_v_q;
        prev_pc_n    = prev_pc_q;
        prev_redir_n = prev_redir_q;
        rd_valid_n   = 1'b0;
        rd_load      = 1'b0;
        lane_pc      = '0;
        lane_err     = 1'b0;
        lane_store   = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            we[l]    = 1'b0;
            waddr[l] = '0;
            werr[l]  = 1'b0;
        end

        if (arm_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_n      = S_ARMED;
            mode_n       = (cfg_mode_i == 2'd3) ? MODE_STOP : cfg_mode_i;
            trig_pc_n    = cfg_trig_pc_i;
            post_n       = cfg_post_cnt_i;
            wr_ptr_n     = '0;
            rd_ptr_n     = '0;
            count_n      = '0;
            overflow_n   = 1'b0;
            err_cnt_n    = '0;
            hist_v_n     = 1'b0;
            prev_pc_n    = '0;
            prev_redir_n = 1'b0;
        end else if (state_q == S_ARMED || state_q == S_POST) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (in_valid_i[l]) begin
                    lane_pc  = in_pc_i[l*XLEN +: XLEN];
                    lane_err = hist_v_n && !prev_redir_n && (lane_pc != prev_pc_n + XLEN'(4));
                    // History tracks the true stream, including entries that end up dropped
                    hist_v_n     = 1'b1;
                    prev_pc_n    = lane_pc;
                    prev_redir_n = in_redirect_i[l];
                    if (state_n == S_ARMED || state_n == S_POST) begin
                        lane_store = 1'b0;
                        if (count_n < CW'(DEPTH)) begin
                            lane_store = 1'b1;
                            count_n    = count_n + CW'(1);
                        end else if (mode_q == MODE_WRAP ||
                                     (mode_q == MODE_TRIG && state_n == S_ARMED)) begin
                            lane_store = 1'b1;
                            rd_ptr_n   = rd_ptr_n + AW'(1);
                            overflow_n = 1'b1;
                        end else begin
                            overflow_n = 1'b1;
                        end
                        if (lane_store) begin
                            we[l]    = 1'b1;
                            waddr[l] = wr_ptr_n;
                            werr[l]  = lane_err;
                            wr_ptr_n = wr_ptr_n + AW'(1);
                            if (lane_err && err_cnt_n != 16'hFFFF) begin
                                err_cnt_n = err_cnt_n + 16'd1;
                            end
                        end
                        if (mode_q == MODE_TRIG && state_n == S_ARMED && lane_pc == trig_pc_q) begin
                            state_n = (post_q == '0) ? S_DONE : S_POST;
                        end else if (state_n == S_POST) begin
                            post_n = post_n - AW'(1);
                            if (post_n == '0) begin
                                state_n = S_DONE;
                            end
                        end
                    end
                end
            end
            if (stop_i) begin
                state_n = S_DONE;
            end
        end else begin
            if (rd_valid_q && rd_ready_i) begin
                rd_ptr_n = rd_ptr_q + AW'(1);
                count_n  = count_q - CW'(1);
            end
            rd_valid_n = (count_n != '0);
            rd_load    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_STOP;
            trig_pc_q    <= '0;
            post_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
            hist_v_q     <= 1'b0;
            prev_pc_q    <= '0;
            prev_redir_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_pc_q      <= '0;
            rd_instr_q   <= '0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_n;
            mode_q       <= mode_n;
            trig_pc_q    <= trig_pc_n;
            post_q       <= post_n;
            wr_ptr_q     <= wr_ptr_n;
            rd_ptr_q     <= rd_ptr_n;
            count_q      <= count_n;
            overflow_q   <= overflow_n;
            err_cnt_q    <= err_cnt_n;
            hist_v_q     <= hist_v_n;
            prev_pc_q    <= prev_pc_n;
            prev_redir_q <= prev_redir_n;
            rd_valid_q   <= rd_valid_n;
            // Reloading from an unchanged pointer keeps data stable under back-pressure
            if (rd_load) begin
                rd_pc_q    <= pc_mem[rd_ptr_n];
                rd_instr_q <= instr_mem[rd_ptr_n];
                rd_err_q   <= err_mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (we[l]) begin
                pc_mem[waddr[l]]    <= in_pc_i[l*XLEN +: XLEN];
                instr_mem[waddr[l]] <= in_instr_i[l*XLEN +: XLEN];
                err_mem[waddr[l]]   <= werr[l];
            end
        end
    end

`ifdef TRACE_TSTAMP_EN
    logic [31:0] tstamp_q;
    logic [31:0] rd_ts_q;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            tstamp_q <= '0;
            rd_ts_q  <= '0;
        end else begin
            tstamp_q <= tstamp_q + 32'd1;
            if (rd_load) begin
                rd_ts_q <= ts_mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (we[l]) begin
                ts_mem[waddr[l]] <= tstamp_q;
            end
        end
    end

    assign rd_tstamp_o = rd_ts_q;
`else
    assign rd_tstamp_o = '0;
`endif

    assign rd_valid_o    = rd_valid_q;
    assign rd_pc_o       = rd_pc_q;
    assign rd_instr_o    = rd_instr_q;
    assign rd_seq_err_o  = rd_err_q;
    assign count_o       = count_q;
    assign state_o       = state_q;
    assign overflow_o    = overflow_q;
    assign seq_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: directed and random streams checked against a queue-based model.
module tb_trace_capture_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_instr;
    logic [1:0]  in_redir;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_trig;
    logic [5:0]  cfg_post;
    logic        arm_i, stop_i, rd_ready_i;
    logic        rd_valid_o, rd_seq_err_o, overflow_o;
    logic [31:0] rd_pc_o, rd_instr_o, rd_tstamp_o;
    logic [6:0]  count_o;
    logic [1:0]  state_o;
    logic [15:0] seq_err_cnt_o;

    int errors;
    int checks;

    trace_capture_buffer #(.XLEN(32), .DEPTH(64), .LANES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_pc_i(in_pc), .in_instr_i(in_instr), .in_redirect_i(in_redir),
        .cfg_mode_i(cfg_mode), .cfg_trig_pc_i(cfg_trig), .cfg_post_cnt_i(cfg_post),
        .arm_i(arm_i), .stop_i(stop_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o), .rd_seq_err_o(rd_seq_err_o),
        .rd_tstamp_o(rd_tstamp_o), .count_o(count_o), .state_o(state_o),
        .overflow_o(overflow_o), .seq_err_cnt_o(seq_err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: the buffer is a queue of entries
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        logic [31:0] ts;
    } ent_t;

    ent_t        m_q[$];
    int          m_state, m_mode, m_post, m_left;
    logic [31:0] m_trig, m_prev, m_ts;
    bit          m_hv, m_prev_redir, m_ovf;
    int          m_errcnt;

    logic [31:0] d_pc[$];
    logic [31:0] d_ts[$];
    logic [63:0] d_errv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        int          st;
        logic [31:0] pc;
        bit          err, stored;
        ent_t        e;
        if (rst) begin
            m_state = 0; m_q.delete(); m_ovf = 0; m_errcnt = 0;
            m_hv = 0; m_prev = '0; m_prev_redir = 0; m_ts = '0;
            return;
        end
        if (arm_i && (m_state == 0 || m_state == 3)) begin
            m_q.delete(); m_ovf = 0; m_errcnt = 0; m_hv = 0; m_state = 1;
            m_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
            m_trig = cfg_trig;
            m_post = int'(cfg_post);
        end else if (m_state == 1 || m_state == 2) begin
            st = m_state;
            for (int l = 0; l < 2; l++) begin
                if (in_valid[l]) begin
                    pc  = in_pc[l*32 +: 32];
                    err = m_hv && !m_prev_redir && (pc != m_prev + 32'd4);
                    m_hv = 1; m_prev = pc; m_prev_redir = in_redir[l];
                    if (st == 1 || st == 2) begin
                        e.pc = pc; e.instr = in_instr[l*32 +: 32]; e.err = err; e.ts = m_ts;
                        stored = 1;
                        if (m_q.size() < 64) m_q.push_back(e);
                        else if (m_mode == 1 || (m_mode == 2 && st == 1)) begin
                            void'(m_q.pop_front());
                            m_q.push_back(e);
                            m_ovf = 1;
                        end else begin
                            stored = 0;
                            m_ovf = 1;
                        end
                        if (stored && err && m_errcnt < 16'hFFFF) m_errcnt++;
                        if (m_mode == 2 && st == 1 && pc == m_trig) begin
                            st = (m_post == 0) ? 3 : 2;
                            m_left = m_post;
                        end else if (st == 2) begin
                            m_left--;
                            if (m_left == 0) st = 3;
                        end
                    end
                end
            end
            if (stop_i) st = 3;
            m_state = st;
        end
        m_ts = m_ts + 32'd1;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input bit v0, input logic [31:0] p0, input bit r0,
                        input bit v1, input logic [31:0] p1, input bit r1);
        in_valid = {v1, v0};
        in_pc    = {p1, p0};
        in_instr = {$urandom, $urandom};
        in_redir = {r1, r0};
        tick();
        in_valid = '0;
        in_redir = '0;
    endtask

    task automatic arm(input logic [1:0] md, input logic [31:0] t, input logic [5:0] p);
        cfg_mode = md; cfg_trig = t; cfg_post = p;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic stop_pulse();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    // Pops n entries, comparing every presented entry (including stalled ones) with the model
    task automatic drain(input string tag, input int n, input bit rnd);
        int   got, guard;
        ent_t e;
        got = 0; guard = 0;
        d_pc.delete(); d_ts.delete(); d_errv = '0;
        while (got < n && guard < 1000) begin
            rd_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rd_valid_o) begin
                e = m_q[0];
                check({tag, ".pc"}, rd_pc_o, e.pc);
                check({tag, ".instr"}, rd_instr_o, e.instr);
                check({tag, ".err"}, 32'(rd_seq_err_o), 32'(e.err));
`ifdef TRACE_TSTAMP_EN
                check({tag, ".ts"}, rd_tstamp_o, e.ts);
`else
                check({tag, ".ts"}, rd_tstamp_o, 32'd0);
`endif
                if (rd_ready_i) begin
                    d_pc.push_back(rd_pc_o);
                    d_ts.push_back(rd_tstamp_o);
                    if (got < 64) d_errv[got] = rd_seq_err_o;
                    void'(m_q.pop_front());
                    got++;
                end
            end
            tick();
            guard++;
        end
        rd_ready_i = 1'b0;
        check({tag, ".drained"}, 32'(got), 32'(n));
    endtask

    function automatic logic [31:0] pc_at(input int i);
        if (i >= 0 && i < d_pc.size()) return d_pc[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ts_at(input int i);
        if (i >= 0 && i < d_ts.size()) return d_ts[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] pc, input bit redir);
        if (redir) return pc + 32'(4 * $urandom_range(2, 20));
        if ($urandom_range(0, 15) == 0) return pc + 32'd8;
        return pc + 32'd4;
    endfunction

    initial begin
        int          i, w;
        logic [1:0]  md;
        logic [31:0] base, pc, trig, p0, p1;
        logic [5:0]  pst;
        int          len;
        bit          v0, v1, r0, r1;
        errors = 0; checks = 0;
        rst = 1'b1; arm_i = 0; stop_i = 0; rd_ready_i = 0;
        in_valid = '0; in_pc = '0; in_instr = '0; in_redir = '0;
        cfg_mode = '0; cfg_trig = '0; cfg_post = '0;
        tick(); tick();
        rst = 1'b0;

        check("reset.state", 32'(state_o), 32'd0);
        check("reset.count", 32'(count_o), 32'd0);
        check("reset.overflow", 32'(overflow_o), 32'd0);
        check("reset.errcnt", 32'(seq_err_cnt_o), 32'd0);
        check("reset.rd_valid", 32'(rd_valid_o), 32'd0);
        check("reset.rd_pc", rd_pc_o, 32'd0);

        // STOP: 70 sequential PCs, first 64 kept
        arm(2'd0, 32'd0, 6'd0);
        check("stop.armed", 32'(state_o), 32'd1);
        for (i = 0; i < 70; i++) feed(1, 32'(i * 4), 0, 0, 32'd0, 0);
        check("stop.count", 32'(count_o), 32'd64);
        check("stop.overflow", 32'(overflow_o), 32'd1);
        check("stop.rd_valid_armed", 32'(rd_valid_o), 32'd0);
        stop_pulse();
        check("stop.done", 32'(state_o), 32'd3);
        drain("stop", 64, 0);
        check("stop.first", pc_at(0), 32'h0);
        check("stop.last", pc_at(63), 32'hFC);
        check("stop.errv", d_errv[31:0], 32'd0);
        check("stop.empty", 32'(count_o), 32'd0);

        // WRAP: last 64 of 70 retained
        arm(2'd1, 32'd0, 6'd0);
        for (i = 0; i < 70; i++) feed(1, 32'h1000 + 32'(i * 4), 0, 0, 32'd0, 0);
        check("wrap.count", 32'(count_o), 32'd64);
        check("wrap.overflow", 32'(overflow_o), 32'd1);
        stop_pulse();
        drain("wrap", 64, 0);
        check("wrap.first", pc_at(0), 32'h1018);
        check("wrap.last", pc_at(63), 32'h1114);

        // TRIG at 0x80 with 3 post-trigger entries
        arm(2'd2, 32'h80, 6'd3);
        i = 0;
        while (state_o != 2'd3 && i < 200) begin
            feed(1, 32'(i * 4), 0, 0, 32'd0, 0);
            i++;
        end
        check("trig.fed", 32'(i), 32'd36);
        check("trig.count", 32'(count_o), 32'd36);
        check("trig.overflow", 32'(overflow_o), 32'd0);
        drain("trig", m_q.size(), 0);
        check("trig.first", pc_at(0), 32'h0);
        check("trig.tail0", pc_at(32), 32'h80);
        check("trig.last", pc_at(35), 32'h8C);

        // Sequence check
        arm(2'd0, 32'd0, 6'd0);
        feed(1, 32'h0, 0, 0, 0, 0);
        feed(1, 32'h4, 0, 0, 0, 0);
        feed(1, 32'h40, 0, 0, 0, 0);
        feed(1, 32'h44, 1, 0, 0, 0);
        feed(1, 32'h200, 0, 0, 0, 0);
        check("seq.errcnt", 32'(seq_err_cnt_o), 32'd1);
        stop_pulse();
        drain("seq", 5, 0);
        check("seq.errv", 32'(d_errv[4:0]), 32'b00100);

        // Dual lane: one free slot, lane 0 stored, lane 1 dropped; then back-pressure hold
        arm(2'd0, 32'd0, 6'd0);
        for (i = 0; i < 31; i++) feed(1, 32'(i * 8), 0, 1, 32'(i * 8 + 4), 0);
        feed(1, 32'hF8, 0, 0, 0, 0);
        check("dual.count63", 32'(count_o), 32'd63);
        feed(1, 32'h100, 0, 1, 32'h104, 0);
        check("dual.count", 32'(count_o), 32'd64);
        check("dual.overflow", 32'(overflow_o), 32'd1);
        stop_pulse();
        w = 0;
        while (!rd_valid_o && w < 5) begin tick(); w++; end
        check("hold.valid", 32'(rd_valid_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("hold.pc", rd_pc_o, 32'h0);
            check("hold.valid_k", 32'(rd_valid_o), 32'd1);
            tick();
        end
        drain("dual", 64, 1);
        check("dual.last", pc_at(63), 32'h100);

        // Arm while a read is pending
        arm(2'd0, 32'd0, 6'd0);
        for (i = 0; i < 64; i++) feed(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0);
        stop_pulse();
        drain("mid", 10, 0);
        check("mid.pending", 32'(rd_valid_o), 32'd1);
        rd_ready_i = 1'b1;
        arm(2'd0, 32'd0, 6'd0);
        rd_ready_i = 1'b0;
        check("mid.rd_valid", 32'(rd_valid_o), 32'd0);
        check("mid.count", 32'(count_o), 32'd0);
        check("mid.overflow", 32'(overflow_o), 32'd0);
        check("mid.state", 32'(state_o), 32'd1);
        feed(1, 32'h500, 0, 0, 0, 0);
        feed(1, 32'h504, 0, 0, 0, 0);
        stop_pulse();
        drain("ts", 2, 0);
`ifdef TRACE_TSTAMP_EN
        check("ts.delta", ts_at(1) - ts_at(0), 32'd1);
`else
        check("ts.zero", ts_at(1), 32'd0);
`endif

        // Reset mid-capture
        arm(2'd1, 32'd0, 6'd0);
        feed(1, 32'h10, 0, 1, 32'h14, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstmid.state", 32'(state_o), 32'd0);
        check("rstmid.count", 32'(count_o), 32'd0);
        check("rstmid.rd_valid", 32'(rd_valid_o), 32'd0);

        // Randomized streams in all modes
        for (int it = 0; it < 8; it++) begin
            md   = 2'($urandom_range(0, 3));
            base = 32'($urandom_range(0, 4095)) << 4;
            trig = base + 32'(4 * $urandom_range(0, 50));
            pst  = 6'($urandom_range(0, 63));
            arm(md, trig, pst);
            pc  = base;
            len = $urandom_range(40, 150);
            for (int k = 0; k < len; k++) begin
                v0 = ($urandom_range(0, 3) != 0);
                v1 = ($urandom_range(0, 1) != 0);
                r0 = ($urandom_range(0, 7) == 0);
                r1 = ($urandom_range(0, 7) == 0);
                p0 = pc;
                if (v0) pc = nxt(pc, r0);
                p1 = pc;
                if (v1) pc = nxt(pc, r1);
                stop_i = ($urandom_range(0, 99) == 0);
                feed(v0, p0, r0, v1, p1, r1);
                stop_i = 1'b0;
            end
            stop_pulse();
            check("rnd.state", 32'(state_o), 32'(m_state));
            check("rnd.count", 32'(count_o), 32'(m_q.size()));
            check("rnd.overflow", 32'(overflow_o), 32'(m_ovf));
            check("rnd.errcnt", 32'(seq_err_cnt_o), 32'(m_errcnt));
            drain("rnd", m_q.size(), 1);
            check("rnd.empty", 32'(count_o), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
